sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
Round-robin arbiter that shares the single Avalon-MM master port to the SDRAM controller between NUM_REQ requester blocks, such as the SDRAM write master and a read master. Each requester presents a simple Avalon-MM-style slave interface. The arbiter captures one command at a time, drives the SDRAM port with registered active-low strobes, and holds the grant until the write is accepted or the read data returns. It sits between the requester blocks and the SDRAM controller slave in the system interconnect.

Parameters:
ADDRESSWIDTH, 25, SDRAM word address width
DATAWIDTH, 32, data bus width
BYTEENABLEWIDTH, 4, byte-enable width (DATAWIDTH/8)
NUM_REQ, 2, number of requesters (2..8)
RD_TIMEOUT, 255, maximum cycles spent in WAIT_RD before the read is abandoned

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_address  in  NUM_REQ*ADDRESSWIDTH  per-requester address, requester i in slice i
req_read  in  NUM_REQ  per-requester read request, active-high
req_write  in  NUM_REQ  per-requester write request, active-high
req_writedata  in  NUM_REQ*DATAWIDTH  per-requester write data
req_byteenable  in  NUM_REQ*BYTEENABLEWIDTH  per-requester byte enables
req_waitrequest  out  NUM_REQ  low only in the cycle requester i's command is captured
req_readdata  out  DATAWIDTH  read data, broadcast to all requesters
req_readdatavalid  out  NUM_REQ  one-cycle pulse to the requester that owns the returning read
address  out  ADDRESSWIDTH  SDRAM address
read_n  out  1  SDRAM read strobe, active-low
write_n  out  1  SDRAM write strobe, active-low
byteenable  out  BYTEENABLEWIDTH  SDRAM byte enables
writedata  out  DATAWIDTH  SDRAM write data
waitrequest  in  1  SDRAM stall
readdata  in  DATAWIDTH  SDRAM read data
readdatavalid  in  1  SDRAM read data valid
error  out  1  sticky error flag, cleared only by reset

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE, read_n=1, write_n=1, address=0, byteenable=0, writedata=0, error=0, rr pointer=NUM_REQ-1 (requester 0 wins first), grant=0, timeout counter=0.
- States are IDLE, ISSUE and WAIT_RD.
- IDLE:
  - A requester is "active" when its req_read or req_write bit is high.
  - The winner is the first active requester searching from pointer+1 modulo NUM_REQ.
  - req_waitrequest[winner]=0 combinationally in that same cycle; every other bit stays 1.
  - On the clock edge the arbiter registers grant=winner and pointer=winner, loads the winner's address, byteenable and writedata onto the SDRAM outputs, drives write_n=0 (write) or read_n=0 (read), and moves to ISSUE.
  - If no requester is active: stay in IDLE, all req_waitrequest=1.
- ISSUE:
  - SDRAM outputs are held stable while waitrequest=1.
  - When waitrequest=0, both strobes go to 1 on the next edge. A write returns to IDLE; a read moves to WAIT_RD with the timeout counter cleared.
- WAIT_RD:
  - When readdatavalid=1: req_readdatavalid[grant]=1 combinationally for that cycle, req_readdata=readdata, next state IDLE.
  - Otherwise the counter increments. If it reaches RD_TIMEOUT: error set, next state IDLE, no readdatavalid pulse is issued.
- req_readdata is driven by readdata at all times.
- readdatavalid seen in IDLE or ISSUE is spurious: error is set and the pulse is not forwarded. This includes data returning after a reset that interrupted a read.
- A requester asserting both read and write in the cycle it is captured: the command is treated as a write and error is set.
- Throughput: at most one transaction per 2 cycles (IDLE capture, then ISSUE accept).
  - Write latency from request to SDRAM strobe: 1 cycle.
  - Minimum read round trip: 3 cycles plus SDRAM latency.
- Fairness: the pointer advances to the last winner, so with requests held continuously, N requesters are served in strict rotation.
- A requester's command is posted once captured. It must not change its request while its req_waitrequest bit is 0.

Decomposition:
- Shared package sdram_arb_pkg:
  - state_t enum {IDLE, ISSUE, WAIT_RD}
  - default width constants (25/32/4)
  - localparam PTR_W=$clog2(NUM_REQ) and the timeout counter width
- Sub-module rr_arbiter, purely combinational:
  - inputs: req vector [NUM_REQ], pointer
  - outputs: winner index, any_req

Test Plan:
- Reset then req_write[0]=1, addr=0x10, data=0xDEADBEEF, be=0xF -> req_waitrequest[0]=0 for 1 cycle; next cycle write_n=0, address=0x10, writedata=0xDEADBEEF; write_n=1 one cycle after waitrequest=0.
- Both requesters write continuously, waitrequest=0 -> grants alternate 0,1,0,1; write_n low every other cycle.
- waitrequest held high 5 cycles during ISSUE -> address, writedata and write_n stable for all 5 cycles; state advances only after waitrequest falls.
- req_read[1]=1, addr=0x1234; SDRAM returns 0xCAFEF00D 3 cycles after acceptance -> req_readdatavalid=2'b10 for exactly 1 cycle, req_readdata=0xCAFEF00D; arbiter back in IDLE; error=0.
- Read with no readdatavalid -> after 255 cycles in WAIT_RD: error=1, state IDLE, no readdatavalid pulse; a new request is then served normally.
- Assert reset_n=0 mid-ISSUE -> read_n=write_n=1 immediately; after release, requester 0 wins first; a late readdatavalid sets error=1.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and width helpers for the SDRAM round-robin arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  localparam int unsigned DEF_ADDRESSWIDTH    = 25;
  localparam int unsigned DEF_DATAWIDTH       = 32;
  localparam int unsigned DEF_BYTEENABLEWIDTH = 4;
  localparam int unsigned DEF_NUM_REQ         = 2;
  localparam int unsigned DEF_RD_TIMEOUT      = 255;

  // Index width that stays legal for a single-entry vector.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned PTR_W = idx_w(DEF_NUM_REQ);
  localparam int unsigned CNT_W = $clog2(DEF_RD_TIMEOUT + 1);

endpackage

// File: rtl/sdram_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first active request after the pointer, wrapping.
module rr_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NumReq = DEF_NUM_REQ,
  parameter int unsigned PtrW   = idx_w(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [PtrW-1:0]   ptr_i,
  output logic [PtrW-1:0]   winner_o,
  output logic              any_req_o
);

  int unsigned idx;

  always_comb begin
    winner_o  = '0;
    any_req_o = 1'b0;
    idx       = 0;
    for (int unsigned k = 1; k <= NumReq; k++) begin
      idx = (32'(ptr_i) + k) % NumReq;
      if (!any_req_o && req_i[idx]) begin
        any_req_o = 1'b1;
        winner_o  = PtrW'(idx);
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one Avalon-MM SDRAM master port between NUM_REQ requesters, one command at a time.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDRESSWIDTH    = DEF_ADDRESSWIDTH,
  parameter int unsigned DATAWIDTH       = DEF_DATAWIDTH,
  parameter int unsigned BYTEENABLEWIDTH = DEF_BYTEENABLEWIDTH,
  parameter int unsigned NUM_REQ         = DEF_NUM_REQ,
  parameter int unsigned RD_TIMEOUT      = DEF_RD_TIMEOUT
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_REQ*ADDRESSWIDTH-1:0]    req_address,
  input  logic [NUM_REQ-1:0]                 req_read,
  input  logic [NUM_REQ-1:0]                 req_write,
  input  logic [NUM_REQ*DATAWIDTH-1:0]       req_writedata,
  input  logic [NUM_REQ*BYTEENABLEWIDTH-1:0] req_byteenable,
  output logic [NUM_REQ-1:0]                 req_waitrequest,
  output logic [DATAWIDTH-1:0]               req_readdata,
  output logic [NUM_REQ-1:0]                 req_readdatavalid,
  output logic [ADDRESSWIDTH-1:0]            address,
  output logic                               read_n,
  output logic                               write_n,
  output logic [BYTEENABLEWIDTH-1:0]         byteenable,
  output logic [DATAWIDTH-1:0]               writedata,
  input  logic                               waitrequest,
  input  logic [DATAWIDTH-1:0]               readdata,
  input  logic                               readdatavalid,
  output logic                               error
);

  localparam int unsigned PtrW = idx_w(NUM_REQ);
  localparam int unsigned CntW = $clog2(RD_TIMEOUT + 1);

  state_t                     state_q, state_d;
  logic [PtrW-1:0]            grant_q, grant_d, ptr_q, ptr_d, winner;
  logic [ADDRESSWIDTH-1:0]    addr_q, addr_d;
  logic [BYTEENABLEWIDTH-1:0] be_q, be_d;
  logic [DATAWIDTH-1:0]       wdata_q, wdata_d;
  logic                       read_n_q, read_n_d, write_n_q, write_n_d;
  logic                       error_q, error_d, any_req;
  logic [CntW-1:0]            cnt_q, cnt_d;

  rr_arbiter #(
    .NumReq(NUM_REQ),
    .PtrW  (PtrW)
  ) u_rr (
    .req_i    (req_read | req_write),
    .ptr_i    (ptr_q),
    .winner_o (winner),
    .any_req_o(any_req)
  );

  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    ptr_d             = ptr_q;
    addr_d            = addr_q;
    be_d              = be_q;
    wdata_d           = wdata_q;
    read_n_d          = read_n_q;
    write_n_d         = write_n_q;
    error_d           = error_q;
    cnt_d             = cnt_q;
    req_waitrequest   = '1;
    req_readdatavalid = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          req_waitrequest[winner] = 1'b0;
          grant_d = winner;
          ptr_d   = winner;
          addr_d  = req_address[winner*ADDRESSWIDTH +: ADDRESSWIDTH];
          be_d    = req_byteenable[winner*BYTEENABLEWIDTH +: BYTEENABLEWIDTH];
          wdata_d = req_writedata[winner*DATAWIDTH +: DATAWIDTH];
          // Read and write together is malformed; the write wins and it is flagged.
          if (req_write[winner]) begin
            write_n_d = 1'b0;
            if (req_read[winner]) error_d = 1'b1;
          end else begin
            read_n_d = 1'b0;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!waitrequest) begin
          read_n_d  = 1'b1;
          write_n_d = 1'b1;
          if (!read_n_q) begin
            state_d = WAIT_RD;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WAIT_RD: begin
        if (readdatavalid) begin
          req_readdatavalid[grant_q] = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (32'(cnt_q) + 32'd1 >= RD_TIMEOUT) begin
            error_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Data with no read outstanding (including one orphaned by reset) is dropped.
    if (readdatavalid && (state_q != WAIT_RD)) error_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= PtrW'(NUM_REQ - 1);
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      read_n_q  <= 1'b1;
      write_n_q <= 1'b1;
      error_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      read_n_q  <= read_n_d;
      write_n_q <= write_n_d;
      error_q   <= error_d;
      cnt_q     <= cnt_d;
    end
  end

  assign address      = addr_q;
  assign byteenable   = be_q;
  assign writedata    = wdata_q;
  assign read_n       = read_n_q;
  assign write_n      = write_n_q;
  assign error        = error_q;
  assign req_readdata = readdata;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed scoreboard bench: stimulus queues expected SDRAM commands and read returns,
// a negedge monitor pops and compares them as the arbiter presents them.
module tb_sdram_arbiter;

  localparam int AW = 25;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int NR = 2;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
  } cmd_t;

  typedef struct packed {
    logic [NR-1:0] vec;
    logic [DW-1:0] data;
  } rd_t;

  logic             clk, reset_n;
  logic [NR*AW-1:0] req_address;
  logic [NR-1:0]    req_read, req_write, req_waitrequest, req_readdatavalid;
  logic [NR*DW-1:0] req_writedata;
  logic [NR*BW-1:0] req_byteenable;
  logic [DW-1:0]    req_readdata, writedata, readdata;
  logic [AW-1:0]    address;
  logic [BW-1:0]    byteenable;
  logic             read_n, write_n, waitrequest, readdatavalid, error;

  cmd_t cmd_q[$];
  rd_t  rd_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  sdram_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_address      (req_address),
    .req_read         (req_read),
    .req_write        (req_write),
    .req_writedata    (req_writedata),
    .req_byteenable   (req_byteenable),
    .req_waitrequest  (req_waitrequest),
    .req_readdata     (req_readdata),
    .req_readdatavalid(req_readdatavalid),
    .address          (address),
    .read_n           (read_n),
    .write_n          (write_n),
    .byteenable       (byteenable),
    .writedata        (writedata),
    .waitrequest      (waitrequest),
    .readdata         (readdata),
    .readdatavalid    (readdatavalid),
    .error            (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [BW-1:0] b);
    req_address[i*AW +: AW]    = a;
    req_writedata[i*DW +: DW]  = d;
    req_byteenable[i*BW +: BW] = b;
  endtask

  task automatic push_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [BW-1:0] b);
    cmd_t c;
    c.wr = wr; c.addr = a; c.data = d; c.be = b;
    cmd_q.push_back(c);
  endtask

  // Returns the req_waitrequest vector of the capture cycle, or all-ones on timeout.
  task automatic wait_capture(output logic [NR-1:0] wr);
    wr = '1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_waitrequest != '1) begin
        wr = req_waitrequest;
        return;
      end
    end
  endtask

  task automatic wait_accept(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((!read_n || !write_n) && !waitrequest) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Monitor: every cycle with a strobe low must match the head command; it retires on accept.
  always @(negedge clk) begin
    if (!write_n || !read_n) begin
      if (cmd_q.size() == 0) begin
        check("unexpected_cmd", 64'({read_n, write_n}), 64'(2'b11));
      end else begin
        check("cmd_strobes", 64'({read_n, write_n}), cmd_q[0].wr ? 64'(2'b10) : 64'(2'b01));
        check("cmd_payload", 64'({address, writedata, byteenable}),
              64'({cmd_q[0].addr, cmd_q[0].data, cmd_q[0].be}));
        if (!waitrequest) void'(cmd_q.pop_front());
      end
    end
    if (req_readdatavalid != '0) begin
      if (rd_q.size() == 0) begin
        check("unexpected_rdvalid", 64'(req_readdatavalid), 64'(0));
      end else begin
        check("rd_return", 64'({req_readdatavalid, req_readdata}),
              64'({rd_q[0].vec, rd_q[0].data}));
        void'(rd_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] wr;
    logic          ok;
    rd_t           r;
    reset_n = 1'b0; req_read = '0; req_write = '0; req_address = '0;
    req_writedata = '0; req_byteenable = '0;
    waitrequest = 1'b0; readdata = '0; readdatavalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_strobes", 64'({read_n, write_n}), 64'(2'b11));
    check("rst_outputs", 64'({address, writedata, byteenable, error}), 64'(0));
    check("rst_waitreq", 64'(req_waitrequest), 64'(2'b11));
    @(posedge clk) #1 reset_n = 1'b1;

    // Single write from requester 0.
    @(posedge clk) #1;
    set_req(0, 25'h10, 32'hDEADBEEF, 4'hF); req_write = 2'b01;
    push_cmd(1'b1, 25'h10, 32'hDEADBEEF, 4'hF);
    wait_capture(wr);
    check("w0_capture", 64'(wr), 64'(2'b10));
    @(posedge clk) #1 req_write = '0;
    @(negedge clk);
    check("w0_waitreq_one_cycle", 64'(req_waitrequest), 64'(2'b11));
    @(negedge clk);
    check("w0_write_n_release", 64'(write_n), 64'(1));

    // Both write continuously; pointer sits at 0 so requester 1 goes first.
    @(posedge clk) #1;
    set_req(0, 25'h100, 32'h0000_1000, 4'hF);
    set_req(1, 25'h200, 32'h0000_2000, 4'h3);
    req_write = 2'b11;
    for (int i = 0; i < 4; i++)
      push_cmd(1'b1, (i % 2 == 0) ? 25'h200 : 25'h100, (i % 2 == 0) ? 32'h2000 : 32'h1000,
               (i % 2 == 0) ? 4'h3 : 4'hF);
    for (int i = 0; i < 4; i++) begin
      wait_capture(wr);
      check("rr_alternate", 64'(wr), (i % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
    end
    @(posedge clk) #1 req_write = '0;

    // Five stalled cycles in ISSUE; the monitor checks hold stability each cycle.
    @(posedge clk) #1;
    waitrequest = 1'b1;
    set_req(0, 25'h40, 32'h11223344, 4'h3); req_write = 2'b01;
    push_cmd(1'b1, 25'h40, 32'h11223344, 4'h3);
    wait_capture(wr);
    check("stall_capture", 64'(wr), 64'(2'b10));
    @(posedge clk) #1 req_write = '0;
    repeat (5) @(negedge clk);
    check("stall_pending", 64'(cmd_q.size()), 64'(1));
    @(posedge clk) #1 waitrequest = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("stall_release", 64'({write_n, cmd_q.size()}), 64'({1'b1, 32'd0}));

    // Read from requester 1, data 3 cycles after acceptance.
    @(posedge clk) #1;
    set_req(1, 25'h1234, 32'h0, 4'hF); req_read = 2'b10;
    push_cmd(1'b0, 25'h1234, 32'h0, 4'hF);
    wait_capture(wr);
    check("rd_capture", 64'(wr), 64'(2'b01));
    @(posedge clk) #1 req_read = '0;
    wait_accept(ok);
    check("rd_accept", 64'(ok), 64'(1));
    r.vec = 2'b10; r.data = 32'hCAFEF00D; rd_q.push_back(r);
    repeat (3) @(posedge clk);
    #1 readdatavalid = 1'b1; readdata = 32'hCAFEF00D;
    @(posedge clk) #1 readdatavalid = 1'b0;
    @(negedge clk);
    check("rd_done", 64'({req_readdatavalid, error, rd_q.size()}), 64'({2'b00, 1'b0, 32'd0}));

    // Read that never returns: abandoned after 255 cycles in WAIT_RD.
    @(posedge clk) #1;
    set_req(0, 25'h55, 32'h0, 4'hF); req_read = 2'b01;
    push_cmd(1'b0, 25'h55, 32'h0, 4'hF);
    wait_capture(wr);
    check("to_capture", 64'(wr), 64'(2'b10));
    @(posedge clk) #1 req_read = '0;
    wait_accept(ok);
    check("to_accept", 64'(ok), 64'(1));
    repeat (255) @(negedge clk);
    check("to_error_not_yet", 64'(error), 64'(0));
    @(negedge clk);
    check("to_error_set", 64'(error), 64'(1));
    @(posedge clk) #1;
    set_req(1, 25'h77, 32'h0BADF00D, 4'hC); req_write = 2'b10;
    push_cmd(1'b1, 25'h77, 32'h0BADF00D, 4'hC);
    wait_capture(wr);
    check("to_next_capture", 64'(wr), 64'(2'b01));
    @(posedge clk) #1 req_write = '0;
    wait_accept(ok);
    check("to_next_accept", 64'(ok), 64'(1));

    // Reset in the middle of a stalled ISSUE.
    @(posedge clk) #1;
    waitrequest = 1'b1;
    set_req(1, 25'h99, 32'h99, 4'h1); req_write = 2'b10;
    push_cmd(1'b1, 25'h99, 32'h99, 4'h1);
    wait_capture(wr);
    check("mid_capture", 64'(wr), 64'(2'b01));
    @(posedge clk) #1 req_write = '0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_strobes", 64'({read_n, write_n}), 64'(2'b11));
    check("mid_rst_outputs", 64'({address, writedata, byteenable, error}), 64'(0));
    cmd_q.delete();
    @(posedge clk) #1 reset_n = 1'b1; waitrequest = 1'b0;
    set_req(0, 25'hA0, 32'hA0, 4'hF);
    set_req(1, 25'hB0, 32'hB0, 4'hF);
    req_write = 2'b11;
    push_cmd(1'b1, 25'hA0, 32'hA0, 4'hF);
    push_cmd(1'b1, 25'hB0, 32'hB0, 4'hF);
    wait_capture(wr);
    check("post_rst_first", 64'(wr), 64'(2'b10));
    @(posedge clk) #1 req_write = 2'b10;
    wait_capture(wr);
    check("post_rst_second", 64'(wr), 64'(2'b01));
    @(posedge clk) #1 req_write = '0;
    wait_accept(ok);
    check("post_rst_accept", 64'({ok, error}), 64'(2'b10));
    @(posedge clk) #1 readdatavalid = 1'b1; readdata = 32'h5A5A5A5A;
    @(posedge clk) #1 readdatavalid = 1'b0;
    @(negedge clk);
    check("late_rdvalid_error", 64'(error), 64'(1));

    // Read and write together: issued as a write and flagged.
    @(posedge clk) #1 reset_n = 1'b0;
    @(posedge clk) #1 reset_n = 1'b1;
    @(negedge clk);
    check("rw_pre_error", 64'(error), 64'(0));
    @(posedge clk) #1;
    set_req(0, 25'hAB, 32'hABABABAB, 4'hF); req_read = 2'b01; req_write = 2'b01;
    push_cmd(1'b1, 25'hAB, 32'hABABABAB, 4'hF);
    wait_capture(wr);
    check("rw_capture", 64'(wr), 64'(2'b10));
    @(posedge clk) #1 req_read = '0; req_write = '0;
    wait_accept(ok);
    check("rw_error", 64'({ok, error}), 64'(2'b11));

    @(negedge clk);
    @(negedge clk);
    check("queues_drained", 64'({cmd_q.size(), rd_q.size()}), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
